sys_control_mm: RTL and testbench
=================================

Name: sys_control_mm

Overview:
Parametrised multi-mode system controller in the 25 MHz display clock domain. It replaces the fixed two-mode controller.
- Sequences camera configuration after reset.
- Debounces the mode button and NUM_FILTERS filter-enable switches.
- Cycles through NUM_MODES processing modes.
- Commits mode and filter changes only at frame boundaries, so the pipeline never switches mid-frame.
- Falls back to a timeout commit when no frames arrive.

Parameters:
- NUM_MODES, 4, number of processing modes (>=2); mode wraps NUM_MODES-1 -> 0.
- NUM_FILTERS, 2, number of independently switchable filter stages (>=1).
- DB_COUNT, 500000, stable cycles required to accept an input change (20 ms at 25 MHz).
- CFG_DELAY, 25000, cycles to wait after reset before pulsing o_cfg_start.
- FRAME_TIMEOUT, 2500000, cycles with pending change and no i_frame_start before forced commit.

Ports:
- i_clk, in, 1, 25 MHz clock.
- i_rst, in, 1, asynchronous active-high reset.
- i_btn_mode, in, 1, raw mode button, asynchronous.
- i_sw_filter, in, NUM_FILTERS, raw filter switches, asynchronous.
- i_frame_start, in, 1, one-cycle frame-start pulse, already in i_clk domain.
- i_cfg_done, in, 1, camera configuration complete (level, i_clk domain).
- o_cfg_start, out, 1, one-cycle configuration start pulse.
- o_mode, out, MODE_W, committed mode.
- o_filter_en, out, NUM_FILTERS, committed filter enables.
- o_pending, out, 1, uncommitted change exists.
- o_state, out, 2, FSM state encoding for status LEDs.

Behaviour:
- Clock and reset: one clock, i_clk. Reset is asynchronous and active-high on i_rst. All flops clear on i_rst assertion.
- Reset values: o_cfg_start=0, o_mode=0, o_filter_en=0, o_pending=0, o_state=S_WAIT, pending registers=0, all counters=0.
- Synchronisation: i_btn_mode and each i_sw_filter bit pass through a 2-flop synchroniser.
- Debounce: each input has its own counter.
  - While the synced value equals the debounced value, the counter resets to 0.
  - Otherwise it increments. When it reaches DB_COUNT-1, the debounced value takes the synced value.
  - Latency from a stable raw change to the debounced change is 2+DB_COUNT cycles.
- Mode press: a rising edge of the debounced button increments pending_mode mod NUM_MODES.
  - Multiple presses between frames accumulate and wrap.
  - Example: NUM_MODES=4, mode 3 plus two presses gives pending 1.
- Filter pending: pending_filter equals the debounced switch vector.
- Pending flag: o_pending = (pending_mode!=o_mode) || (pending_filter!=o_filter_en), registered, 1-cycle lag.
- FSM:
  - S_WAIT (0): count to CFG_DELAY-1, then go to S_CFG.
  - S_CFG (1): assert o_cfg_start for exactly one cycle, then go to S_CFGWAIT.
  - S_CFGWAIT (2): hold until i_cfg_done=1, then go to S_RUN.
  - S_RUN (3): stay; commits are allowed only in this state.
- Before S_RUN: presses and switch changes still update the pending registers, but nothing is committed.
- On entering S_RUN: if anything is pending, the first commit happens at the first i_frame_start.
- Commit: in S_RUN, when o_pending=1 and (i_frame_start=1 or timeout_cnt==FRAME_TIMEOUT-1):
  - o_mode <= pending_mode and o_filter_en <= pending_filter on the next edge.
  - timeout_cnt clears.
- Timeout counter: increments only while o_pending=1 and i_frame_start=0. It clears on commit or when pending drops.
- Simultaneous press and i_frame_start: the commit uses the pre-increment pending_mode. The new increment stays pending for the next frame.
- Transient change: if a switch toggles and returns before the commit, pending clears and no commit or output change occurs.
- Reset mid-operation (including S_CFGWAIT): everything returns to reset values and the configuration sequence restarts from S_WAIT.
- Width: MODE_W = max(1, clog2(NUM_MODES)). The mode increment compares against NUM_MODES-1 explicitly; it must not rely on natural overflow, so non-power-of-2 counts are correct.

Decomposition:
- Package sys_ctrl_pkg:
  - state enum (S_WAIT, S_CFG, S_CFGWAIT, S_RUN) with 2-bit encoding.
  - MODE_W calculation function.
- Sub-module debounce_sync: 2-flop synchroniser plus debounce counter. Parameter DB_COUNT, ports i_clk, i_rst, i_in, o_db. Instantiated NUM_FILTERS+1 times via generate.

Test Plan:
All scenarios use DB_COUNT=4, CFG_DELAY=8, FRAME_TIMEOUT=50, NUM_MODES=3.
- Power-up: release i_rst at cycle 0 -> o_cfg_start high for exactly one cycle at cycle 9 (S_WAIT exits after 8 cycles); o_state=2 until i_cfg_done=1; then o_state=3.
- Debounce: button glitches high 3 cycles, then stable high 10 cycles -> exactly one increment; pending_mode=1; o_mode stays 0 until i_frame_start, then o_mode=1 and o_pending=0.
- Wrap and accumulate: from o_mode=2, four clean presses before a frame -> o_mode=0 after the frame (2+4 mod 3), then 0 -> 1 on the next press plus frame.
- Timeout: set i_sw_filter=2'b10, no i_frame_start -> o_filter_en=2'b10 exactly 50 cycles after o_pending rises.
- Simultaneity and reset: press edge in the same cycle as i_frame_start -> committed o_mode excludes that press and o_pending stays 1. Separately, assert i_rst during S_CFGWAIT -> all outputs 0 and o_cfg_start re-pulses after CFG_DELAY.

Source files
------------

// File: rtl/sys_ctrl_pkg.sv
// sys_ctrl_pkg: shared types and helpers
// for the multi-mode system controller.
package sys_ctrl_pkg;

  typedef enum logic [1:0] {
    S_WAIT    = 2'd0,
    S_CFG     = 2'd1,
    S_CFGWAIT = 2'd2,
    S_RUN     = 2'd3
  } state_t;

  function automatic int mode_w(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/debounce_sync.sv
// debounce_sync: 2-flop synchroniser
// followed by a stable-count debouncer.
module debounce_sync #(
  parameter int DB_COUNT = 500000
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_in,
  output logic o_db
);

  localparam int CW =
    (DB_COUNT > 1) ? $clog2(DB_COUNT) : 1;
  localparam logic [CW-1:0] CNT_LAST =
    CW'(DB_COUNT - 1);

  logic          s1;
  logic          s2;
  logic [CW-1:0] cnt;

  // bring the raw input into the clock domain
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= i_in;
      s2 <= s1;
    end
  end

  // accept a new level only after it stays put
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      cnt  <= '0;
      o_db <= 1'b0;
    end else if (s2 == o_db) begin
      cnt <= '0;
    end else if (cnt == CNT_LAST) begin
      cnt  <= '0;
      o_db <= s2;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/sys_control_mm.sv
// sys_control_mm: camera config sequencing
// and frame-aligned mode/filter commits.
module sys_control_mm
  import sys_ctrl_pkg::*;
#(
  parameter int NUM_MODES     = 4,
  parameter int NUM_FILTERS   = 2,
  parameter int DB_COUNT      = 500000,
  parameter int CFG_DELAY     = 25000,
  parameter int FRAME_TIMEOUT = 2500000,
  localparam int MODE_W = mode_w(NUM_MODES)
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_btn_mode,
  input  logic [NUM_FILTERS-1:0] i_sw_filter,
  input  logic                   i_frame_start,
  input  logic                   i_cfg_done,
  output logic                   o_cfg_start,
  output logic [MODE_W-1:0]      o_mode,
  output logic [NUM_FILTERS-1:0] o_filter_en,
  output logic                   o_pending,
  output logic [1:0]             o_state
);

  localparam int CDW =
    (CFG_DELAY > 1) ? $clog2(CFG_DELAY) : 1;
  localparam int TW =
    (FRAME_TIMEOUT > 1) ? $clog2(FRAME_TIMEOUT) : 1;
  localparam logic [CDW-1:0] CFG_LAST =
    CDW'(CFG_DELAY - 1);
  localparam logic [TW-1:0] TO_LAST =
    TW'(FRAME_TIMEOUT - 1);
  localparam logic [MODE_W-1:0] MODE_LAST =
    MODE_W'(NUM_MODES - 1);

  state_t                 state;
  state_t                 state_n;
  logic                   cfg_start_n;
  logic [CDW-1:0]         cfg_cnt;
  logic [TW-1:0]          timeout_cnt;
  logic [MODE_W-1:0]      pending_mode;
  logic [MODE_W-1:0]      mode_inc;
  logic [NUM_FILTERS-1:0] pending_filter;
  logic [NUM_FILTERS:0]   raw_in;
  logic [NUM_FILTERS:0]   db_out;
  logic                   btn_db_q;
  logic                   btn_rise;
  logic                   commit;

  assign raw_in = {i_sw_filter, i_btn_mode};

  for (genvar i = 0; i <= NUM_FILTERS; i++) begin : g_db
    debounce_sync #(
      .DB_COUNT(DB_COUNT)
    ) u_db (
      .i_clk(i_clk),
      .i_rst(i_rst),
      .i_in (raw_in[i]),
      .o_db (db_out[i])
    );
  end

  assign pending_filter = db_out[NUM_FILTERS:1];
  assign btn_rise = db_out[0] & ~btn_db_q;
  assign mode_inc = (pending_mode == MODE_LAST) ?
                    '0 : pending_mode + 1'b1;
  assign commit = (state == S_RUN) && o_pending &&
                  (i_frame_start ||
                   timeout_cnt == TO_LAST);
  assign o_state = state;

  // configuration sequencer next state
  always_comb begin
    state_n     = state;
    cfg_start_n = 1'b0;
    unique case (state)
      S_WAIT:
        if (cfg_cnt == CFG_LAST) state_n = S_CFG;
      S_CFG: begin
        state_n     = S_CFGWAIT;
        cfg_start_n = 1'b1;
      end
      S_CFGWAIT:
        if (i_cfg_done) state_n = S_RUN;
      S_RUN:
        state_n = S_RUN;
    endcase
  end

  // sequencer state, delay counter, start pulse
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state       <= S_WAIT;
      cfg_cnt     <= '0;
      o_cfg_start <= 1'b0;
    end else begin
      state       <= state_n;
      o_cfg_start <= cfg_start_n;
      if (state == S_WAIT && state_n == S_WAIT)
        cfg_cnt <= cfg_cnt + 1'b1;
      else
        cfg_cnt <= '0;
    end
  end

  // accumulate presses and flag uncommitted changes
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      btn_db_q     <= 1'b0;
      pending_mode <= '0;
      o_pending    <= 1'b0;
    end else begin
      btn_db_q  <= db_out[0];
      o_pending <= (pending_mode != o_mode) ||
                   (pending_filter != o_filter_en);
      if (btn_rise) pending_mode <= mode_inc;
    end
  end

  // frame-aligned commit with no-frame timeout
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_mode      <= '0;
      o_filter_en <= '0;
      timeout_cnt <= '0;
    end else if (commit) begin
      o_mode      <= pending_mode;
      o_filter_en <= pending_filter;
      timeout_cnt <= '0;
    end else if (state == S_RUN && o_pending &&
                 !i_frame_start) begin
      timeout_cnt <= timeout_cnt + 1'b1;
    end else begin
      timeout_cnt <= '0;
    end
  end

endmodule

// File: tb/tb_sys_control_mm.sv
// tb_sys_control_mm: table, directed and
// randomized checks against a window model.
module tb_sys_control_mm;

  localparam int NM = 3;
  localparam int DB = 4;
  localparam int CD = 8;
  localparam int TO = 50;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       btn = 1'b0;
  logic [1:0] sw = 2'b00;
  logic       fs = 1'b0;
  logic       done = 1'b0;
  logic       cfg_start;
  logic [1:0] mode;
  logic [1:0] filt;
  logic       pend;
  logic [1:0] st;

  int checks = 0;
  int errors = 0;

  sys_control_mm #(
    .NUM_MODES    (NM),
    .NUM_FILTERS  (2),
    .DB_COUNT     (DB),
    .CFG_DELAY    (CD),
    .FRAME_TIMEOUT(TO)
  ) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_btn_mode   (btn),
    .i_sw_filter  (sw),
    .i_frame_start(fs),
    .i_cfg_done   (done),
    .o_cfg_start  (cfg_start),
    .o_mode       (mode),
    .o_filter_en  (filt),
    .o_pending    (pend),
    .o_state      (st)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit done;
    int cfg;
    int st;
  } vec_t;

  vec_t tbl[12];

  // reference model: cycle-level behaviour
  int m_state, m_wait, m_cfg, m_mode;
  int m_filt, m_pend, m_pmode, m_tcnt;
  bit m_db[3];
  bit m_dbq;
  bit m_h[3][8];

  task automatic check(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d",
               name, act, exp);
    end
  endtask

  function automatic bit raw_in(int k);
    return (k == 0) ? btn : sw[k-1];
  endfunction

  task automatic model_reset();
    m_state = 0; m_wait = 0; m_cfg = 0;
    m_mode = 0; m_filt = 0; m_pend = 0;
    m_pmode = 0; m_tcnt = 0; m_dbq = 0;
    for (int k = 0; k < 3; k++) begin
      m_db[k] = 0;
      for (int j = 0; j < 8; j++) m_h[k][j] = 0;
    end
  endtask

  task automatic model_edge();
    bit ndb[3];
    bit diff;
    bit rise;
    bit cm;
    int pf;
    int ns, nw;
    for (int k = 0; k < 3; k++) begin
      // flips once the samples seen 2..DB+1 edges
      // ago all disagree with the current level
      diff = 1;
      for (int j = 1; j <= DB; j++)
        if (m_h[k][j] == m_db[k]) diff = 0;
      ndb[k] = diff ? !m_db[k] : m_db[k];
      for (int j = 7; j > 0; j--)
        m_h[k][j] = m_h[k][j-1];
      m_h[k][0] = raw_in(k);
    end
    pf = 2 * int'(m_db[2]) + int'(m_db[1]);
    rise = m_db[0] && !m_dbq;
    cm = (m_state == 3) && (m_pend != 0) &&
         (fs || m_tcnt == TO - 1);
    ns = m_state;
    nw = 0;
    case (m_state)
      0: if (m_wait == CD - 1) ns = 1;
         else nw = m_wait + 1;
      1: ns = 2;
      2: if (done) ns = 3;
      default: ns = 3;
    endcase
    m_cfg = (m_state == 1) ? 1 : 0;
    if (cm) m_tcnt = 0;
    else if (m_state == 3 && m_pend != 0 && !fs)
      m_tcnt = m_tcnt + 1;
    else m_tcnt = 0;
    m_pend = ((m_pmode != m_mode) ||
              (pf != m_filt)) ? 1 : 0;
    if (cm) begin
      m_mode = m_pmode;
      m_filt = pf;
    end
    if (rise) m_pmode = (m_pmode + 1) % NM;
    m_dbq = m_db[0];
    for (int k = 0; k < 3; k++) m_db[k] = ndb[k];
    m_state = ns;
    m_wait = nw;
  endtask

  task automatic step();
    @(posedge clk);
    if (!rst) model_edge();
    #1;
    check("model_mode", mode, m_mode);
    check("model_filt", filt, m_filt);
    check("model_pend", pend, m_pend);
    check("model_state", st, m_state);
    check("model_cfg", cfg_start, m_cfg);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic powerup(int n);
    for (int i = 0; i < n; i++) begin
      done = tbl[i].done;
      step();
      check("pu_cfg", cfg_start, tbl[i].cfg);
      check("pu_state", st, tbl[i].st);
      check("pu_mode", mode, 0);
      check("pu_filt", filt, 0);
      check("pu_pend", pend, 0);
    end
  endtask

  task automatic press();
    btn = 1'b1;
    repeat (5) step();
    btn = 1'b0;
    repeat (6) step();
  endtask

  task automatic frame();
    fs = 1'b1;
    step();
    fs = 1'b0;
    repeat (2) step();
  endtask

  initial begin
    int n;
    for (int i = 0; i < 12; i++)
      tbl[i] = '{done: 1'b0, cfg: 0, st: 0};
    tbl[7].st = 1;
    tbl[8] = '{done: 1'b0, cfg: 1, st: 2};
    tbl[9].st = 2;
    tbl[10].st = 2;
    tbl[11] = '{done: 1'b1, cfg: 0, st: 3};

    model_reset();
    #1;
    check("rst_mode", mode, 0);
    check("rst_pend", pend, 0);
    check("rst_cfg", cfg_start, 0);
    check("rst_state", st, 0);
    do_reset();
    powerup(12);
    done = 1'b1;

    // glitch rejected, then one clean press
    btn = 1'b1;
    repeat (3) step();
    btn = 1'b0;
    repeat (6) step();
    btn = 1'b1;
    repeat (10) step();
    btn = 1'b0;
    repeat (4) step();
    check("db_hold_mode", mode, 0);
    check("db_hold_pend", pend, 1);
    frame();
    check("db_commit_mode", mode, 1);
    check("db_commit_pend", pend, 0);

    // wrap and accumulate
    press();
    frame();
    check("wrap_pre", mode, 2);
    repeat (4) press();
    check("wrap_hold", mode, 2);
    frame();
    check("wrap_mode", mode, 0);
    press();
    frame();
    check("wrap_next", mode, 1);

    // timeout commit with no frames
    sw = 2'b10;
    n = 0;
    while (!pend && n < 20) begin
      step();
      n++;
    end
    check("to_pend_rise", pend, 1);
    n = 0;
    while (filt != 2'b10 && n < 100) begin
      step();
      n++;
    end
    check("to_latency", n, TO);
    check("to_mode", mode, 1);

    // press edge coincident with frame start
    press();
    btn = 1'b1;
    n = 0;
    while (!(m_db[0] && !m_dbq) && n < 10) begin
      step();
      n++;
    end
    check("simul_edge_found", int'(n < 10), 1);
    fs = 1'b1;
    step();
    fs = 1'b0;
    check("simul_mode", mode, 2);
    btn = 1'b0;
    repeat (6) step();
    check("simul_pend", pend, 1);
    frame();
    check("simul_next", mode, 0);
    check("simul_clear", pend, 0);

    // reset while waiting for cfg_done
    sw = 2'b00;
    done = 1'b0;
    do_reset();
    powerup(10);
    rst = 1'b1;
    #1;
    check("arst_mode", mode, 0);
    check("arst_filt", filt, 0);
    check("arst_pend", pend, 0);
    check("arst_state", st, 0);
    check("arst_cfg", cfg_start, 0);
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    powerup(12);
    done = 1'b1;

    // randomized traffic, one block without frames
    for (int blk = 0; blk < 4; blk++) begin
      for (int c = 0; c < 500; c++) begin
        if ($urandom % 8 == 0) btn = ~btn;
        if ($urandom % 16 == 0) begin
          n = int'($urandom % 2);
          sw[n] = ~sw[n];
        end
        fs = (blk != 2) && ($urandom % 20 == 0);
        step();
      end
    end
    fs = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
